serial_add32: RTL
=================

Name: serial_add32

Overview:
- Nibble-serial adder: adds two WIDTH-bit operands 4 bits per clock through one 4-bit carry-chain slice.
- Sits downstream of the 4-bit adder slice and consumes its sum and carry-out each cycle.
- Gives a small-area alternative to a full-width ripple adder for multi-cycle datapath use, such as address/offset adds in a non-critical path.
- Uses a start/busy/done handshake toward the controller.

Parameters:
- WIDTH, 32, operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- cin  input  1  carry-in to bit 0; captured when start is accepted
- busy  output  1  high while nibble steps are in progress
- done  output  1  one-cycle pulse; result valid
- s  output  WIDTH  sum; held from done until the next accepted start completes
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (synchronous, active-high): when reset=1 at an edge, the following clear, with reset taking priority over every other input:
  - busy=0, done=0, s=0, cout=0, overflow=0
  - nibble counter=0, state=IDLE
- Reset during RUN aborts the operation and produces no done pulse.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - No separate DONE state; done is a registered pulse.
- IDLE -> RUN:
  - Trigger: start=1 at an edge while busy=0.
  - Captures a, b and cin into operand shift registers and the carry register.
  - Clears the counter.
  - Clears done.
- RUN, each edge:
  - Slice computes nibble k (k = counter, 0..NIB-1) from the low nibbles of the operand registers plus the carry register.
  - The 4-bit sum shifts into the MSB end of the result shift register.
  - Slice carry-out goes to the carry register.
  - Operand registers shift right by 4.
  - Counter increments.
- RUN -> IDLE on the edge processing k=NIB-1. On that same edge:
  - s takes the final value.
  - cout takes the slice carry-out.
  - overflow takes (carry into slice bit 3) XOR (slice carry-out).
  - done=1, busy=0.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+NIB (8 cycles for WIDTH=32).
- done falls on the next edge unless reset.
- Back-to-back: start=1 while done=1 is accepted, because busy=0. s/cout/overflow stay unchanged until the new operation's final edge.
- start while busy=1 is ignored: no queuing, no error.
- s, cout and overflow change only on the final RUN edge or on reset. They never show partial sums.
- Arithmetic: modulo 2^WIDTH. cout is the unsigned carry. No sign extension.

Decomposition:
- Shared package/include:
  - Nibble width constant (4).
  - State encoding constants: ST_IDLE=0, ST_RUN=1.
- Counter width is $clog2(NIB).
- One sub-module: add4_cin, a 4-bit slice with carry-in.
  - Ports: a[3:0], b[3:0], cin, s[3:0], c3 (carry into bit 3), cout.
  - Built from the existing full_adder cell.
  - Instantiated once; no other hierarchy.

Test Plan:
1. Reset: hold reset 2 cycles, then release -> busy=0, done=0, s=0, cout=0, overflow=0.
2. Basic add: a=0x0000_0007, b=0x0000_0009, cin=0, start 1 cycle -> busy high 8 cycles; done pulse one cycle later; s=0x0000_0010, cout=0, overflow=0.
3. Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> s=0x0000_0000, cout=1, overflow=0.
4. Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> s=0x8000_0000, cout=0, overflow=1. Also a=0x8000_0000, b=0x8000_0000 -> s=0, cout=1, overflow=1.
5. Handshake:
   - Pulse start with a=1, b=1.
   - Assert start again mid-RUN with a=5, b=5 -> ignored; result s=2.
   - Then start with a=5, b=5 in the done cycle -> accepted; next done gives s=0x0A; s holds 2 until then.
6. Reset mid-op: start a=0x1234_5678, b=0x1111_1111; assert reset at step 4 -> no done pulse; outputs 0. A following start gives s=0x2345_6789, cout=0.

Source files
------------

// File: rtl/serial_add32_pkg.sv
// -----------------------------------------------------------------------------
// serial_add32_pkg
// Shared constants for the nibble-serial adder: the slice width and the
// controller state encoding.
// -----------------------------------------------------------------------------
package serial_add32_pkg;

    // Width of the carry-chain slice; one nibble is consumed per clock.
    localparam int NIBW = 4;

    // Controller state encoding. There is no DONE state; done is a registered
    // pulse raised on the final RUN edge.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : serial_add32_pkg

// File: rtl/serial_add32_if.sv
// -----------------------------------------------------------------------------
// serial_add32_if
// Start/busy/done handshake plus operand and result bus for serial_add32.
//   start    : request, honoured only while busy=0
//   a, b     : operands, captured when start is accepted
//   cin      : carry-in to bit 0, captured with the operands
//   busy     : nibble steps in progress
//   done     : one-cycle pulse, result valid
//   s        : sum, held until the next accepted operation completes
//   cout     : unsigned carry out of bit WIDTH-1
//   overflow : signed overflow (carry into MSB xor carry out of MSB)
// master = controller side, slave = adder side.
// -----------------------------------------------------------------------------
interface serial_add32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout, overflow
    );
endinterface : serial_add32_if

// File: rtl/add4_cin.sv
// -----------------------------------------------------------------------------
// add4_cin
// 4-bit ripple slice with carry-in, built from full_adder cells. Also exposes
// the carry into bit 3 so the caller can form signed overflow on the top
// nibble.
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   c3   : carry into bit 3
//   cout : carry out of bit 3
// -----------------------------------------------------------------------------
module add4_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       c3,
    output logic       cout
);
    // c[i] is the carry into bit i; c[4] is the carry out of the slice.
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign c3   = c[3];
    assign cout = c[4];
endmodule : add4_cin

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   a, b, ci : addend bits and carry-in
//   s        : sum bit
//   co       : carry-out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule : full_adder

// File: rtl/serial_add32.sv
// -----------------------------------------------------------------------------
// serial_add32
// Nibble-serial adder: adds two WIDTH-bit operands four bits per clock through
// a single add4_cin slice. WIDTH must be a multiple of 4 and at least 8; a
// result appears WIDTH/4 clocks after start is accepted.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation in progress
//   bus   : slave side of serial_add32_if (start/a/b/cin in,
//           busy/done/s/cout/overflow out)
// -----------------------------------------------------------------------------
module serial_add32
    import serial_add32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    serial_add32_if.slave bus
);
    localparam int NIB = WIDTH / NIBW;
    localparam int CW  = $clog2(NIB);

    logic [0:0]            state;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      opa;
    logic [WIDTH-1:0]      opb;
    logic                  carry;
    // Nibbles finished so far, newest at the top; the final step supplies
    // the last nibble, so only WIDTH-4 bits need storing.
    logic [WIDTH-NIBW-1:0] acc;

    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIBW-1:0]  sum4;
    logic             c3;
    logic             c4;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] acc_next;

    add4_cin u_slice (
        .a    (opa[NIBW-1:0]),
        .b    (opb[NIBW-1:0]),
        .cin  (carry),
        .s    (sum4),
        .c3   (c3),
        .cout (c4)
    );

    assign accept   = (state == ST_IDLE) && bus.start;
    assign last     = (cnt == CW'(NIB - 1));
    assign acc_next = {sum4, acc};

    // Control and the visible result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees pre-edge values of the others regardless of order.
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                        s_q    <= acc_next;
                        cout_q <= c4;
                        // Only on the top nibble does c3 equal the carry
                        // into the MSB.
                        ovf_q  <= c3 ^ c4;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the operand, carry and partial-sum registers carry no reset; they
    // are always reloaded on accept before use, and nothing visible depends
    // on them while idle.
    always_ff @(posedge clk) begin
        if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b;
            carry <= bus.cin;
        end else if (state == ST_RUN) begin
            opa   <= opa >> NIBW;
            opb   <= opb >> NIBW;
            carry <= c4;
            acc   <= acc_next[WIDTH-1:NIBW];
        end
    end

    assign bus.busy     = (state == ST_RUN);
    assign bus.done     = done_q;
    assign bus.s        = s_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule : serial_add32
